// File: rtl/bcd_display_mux.sv
// Time-multiplexed 7-segment driver for a packed BCD value. Input is staged on
// load and applied to the scanned shadow copy only at frame wrap.
module bcd_display_mux #(
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 1000,
  parameter int DEAD          = 2,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRESC_DEAD = PW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic          INV        = (ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_OFF = {7{INV}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{INV}};

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   stage_bcd_q, stage_bcd_d;
  logic [DIGITS-1:0]     stage_dp_q, stage_dp_d;
  logic [4*DIGITS-1:0]   shadow_bcd_q, shadow_bcd_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  logic                  frame_q, frame_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  slot_wrap_s;
  logic                  frame_wrap_s;
  logic [DIGITS-1:0]     blank_s;
  logic                  zero_run_s;
  logic [3:0]            cur_digit_s;
  logic                  cur_dp_s;

  // Scan counters and the staging/shadow handoff.
  always_comb begin
    slot_wrap_s  = (presc_q == PRESC_LAST);
    frame_wrap_s = slot_wrap_s && (idx_q == IDX_LAST);

    if (slot_wrap_s) begin
      presc_d = {PW{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
    end

    if (frame_wrap_s && pending_q) begin
      shadow_bcd_d = stage_bcd_q;
      shadow_dp_d  = stage_dp_q;
    end else begin
      shadow_bcd_d = shadow_bcd_q;
      shadow_dp_d  = shadow_dp_q;
    end

    // A load coinciding with the wrap refills staging and stays pending.
    if (load) begin
      stage_bcd_d = bcd_in;
      stage_dp_d  = dp_in;
      pending_d   = 1'b1;
    end else if (frame_wrap_s) begin
      stage_bcd_d = stage_bcd_q;
      stage_dp_d  = stage_dp_q;
      pending_d   = 1'b0;
    end else begin
      stage_bcd_d = stage_bcd_q;
      stage_dp_d  = stage_dp_q;
      pending_d   = pending_q;
    end

    frame_d = frame_wrap_s;
  end

  // Leading-zero blanking mask, walking down from the most significant digit.
  always_comb begin
    blank_s    = {DIGITS{1'b0}};
    zero_run_s = (BLANK_LEADING != 0);
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run_s = zero_run_s && (shadow_bcd_q[4*k +: 4] == 4'd0);
      blank_s[k] = zero_run_s;
    end
  end

  // Output decode for the slot currently addressed by (idx, presc).
  always_comb begin
    cur_digit_s = shadow_bcd_q[{idx_q, 2'b00} +: 4];
    cur_dp_s    = shadow_dp_q[idx_q];
    if ((presc_q >= PRESC_DEAD) && !blank_s[idx_q]) begin
      an_d  = AN_OFF ^ (DIGITS'(1) << idx_q);
      seg_d = SEG_OFF ^ decode7(cur_digit_s);
      dp_d  = INV ^ cur_dp_s;
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = INV;
    end
  end

  // State and registered outputs; clr forces the display dark immediately.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc_q      <= {PW{1'b0}};
      idx_q        <= {IW{1'b0}};
      stage_bcd_q  <= {(4*DIGITS){1'b0}};
      stage_dp_q   <= {DIGITS{1'b0}};
      shadow_bcd_q <= {(4*DIGITS){1'b0}};
      shadow_dp_q  <= {DIGITS{1'b0}};
      pending_q    <= 1'b0;
      frame_q      <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= INV;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      stage_bcd_q  <= stage_bcd_d;
      stage_dp_q   <= stage_dp_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      frame_q      <= frame_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: a cycle-count based model of the scan predicts
// every output each clock, driven by directed and random load traffic.
module tb_bcd_display_mux;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  bcd_display_mux #(
    .DIGITS(4), .REFRESH_DIV(8), .DEAD(2), .ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .clr(clr), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Active-high glyphs for codes 0..15.
  logic [6:0] seg_tab [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000
  };

  // Model state: clocks since reset release, staged and displayed values.
  int          cyc;
  logic [15:0] m_stage, m_shadow;
  logic [3:0]  m_stage_dp, m_shadow_dp;
  logic        m_pend;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    m_stage = 16'h0; m_shadow = 16'h0;
    m_stage_dp = 4'h0; m_shadow_dp = 4'h0;
    m_pend = 1'b0;
  endtask

  // One clock: predict outputs from the pre-edge state, advance model, compare.
  task automatic tick();
    int         slot, phase;
    logic       act;
    logic [3:0] dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fr;
    @(posedge clk);
    slot  = (cyc / 8) % 4;
    phase = cyc % 8;
    dig   = 4'((m_shadow >> (4 * slot)) & 16'hF);
    act   = (phase >= 2) && ((slot == 0) || ((m_shadow >> (4 * slot)) != 16'h0));
    e_an  = act ? (4'hF & ~(4'h1 << slot)) : 4'hF;
    e_seg = act ? ~seg_tab[dig] : 7'h7F;
    e_dp  = act ? ~m_shadow_dp[slot] : 1'b1;
    e_fr  = (cyc % 32 == 31);
    if (e_fr && m_pend) begin
      m_shadow = m_stage; m_shadow_dp = m_stage_dp; m_pend = 1'b0;
    end
    if (load) begin
      m_stage = bcd_in; m_stage_dp = dp_in; m_pend = 1'b1;
    end
    cyc++;
    @(negedge clk);
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("dp", 32'(dp), 32'(e_dp));
    check_eq("frame", 32'(frame), 32'(e_fr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 64 && (cyc % 32) != p; i++) tick();
  endtask

  // Assert clr between edges, check outputs go dark at once, release at negedge.
  task automatic mid_reset();
    #2 clr = 1'b0;
    #1;
    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_seg", 32'(seg), 32'h7F);
    check_eq("rst_dp", 32'(dp), 32'h1);
    check_eq("rst_frame", 32'(frame), 32'h0);
    @(negedge clk);
    clr = 1'b1;
    model_reset();
  endtask

  initial begin
    int first_an, first_fr, an0_cnt, fr_cnt, bad_hot;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("por_an", 32'(an), 32'hF);
    check_eq("por_frame", 32'(frame), 32'h0);
    clr = 1'b1;

    // Start-up timing and free-run with an all-zero shadow.
    first_an = 0; first_fr = 0; an0_cnt = 0; fr_cnt = 0; bad_hot = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (an != 4'hF && first_an == 0) first_an = i;
      if (!an[0]) an0_cnt++;
      if (an[3:1] != 3'b111) bad_hot++;
      if (frame) begin
        fr_cnt++;
        if (first_fr == 0) first_fr = i;
      end
    end
    check_eq("first_an_edge", 32'(first_an), 32'd3);
    check_eq("first_frame_edge", 32'(first_fr), 32'd32);
    check_eq("an0_low_per_frame", 32'(an0_cnt), 32'd6);
    check_eq("frames_per_32", 32'(fr_cnt), 32'd1);
    check_eq("only_an0_used", 32'(bad_hot), 32'd0);

    run(13);
    mid_reset();
    run(40);

    do_load(16'h1205, 4'b0000); run(70);
    do_load(16'h0042, 4'b0000); run(70);
    do_load(16'h00A3, 4'b0000); run(70);

    // Two loads in one frame, a third on the wrap edge.
    wait_phase(5);  do_load(16'h1111, 4'b0000);
    wait_phase(20); do_load(16'h2222, 4'b0000);
    wait_phase(31); do_load(16'h3333, 4'b0000);
    run(96);

    do_load(16'h1234, 4'b0100); run(70);

    // Random traffic, including random BCD/non-BCD codes and a stray reset.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        do_load(16'($urandom), 4'($urandom));
      end else if (i == 600) begin
        mid_reset();
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
